// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request arbiter.
package fpu_pkg;

    // Arbiter control states: one request is in flight from ISSUE through RESP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Quiet NaN returned to the requester when the FPU never answers.
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Opcodes understood by the shared FPU; the arbiter only forwards them.
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;

endpackage

// File: rtl/fpu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // One-hot grant from the request vector and the last-served id.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one multi-cycle FPU between two requesters: round-robin grant,
// single outstanding operation, start pulse, done/timeout, held response.
module fpu_req_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 64,
    parameter int unsigned TMO_W      = 7
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [1:0][3:0]  i_req_op,
    input  logic [1:0][31:0] i_req_a,
    input  logic [1:0][31:0] i_req_b,
    output logic [1:0]       o_rsp_valid,
    input  logic [1:0]       i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic             o_rsp_err,
    output logic             o_fpu_start,
    output logic [3:0]       o_fpu_op,
    output logic [31:0]      o_fpu_a,
    output logic [31:0]      o_fpu_b,
    input  logic             i_fpu_done,
    input  logic [31:0]      i_fpu_result,
    output logic             o_busy
);

    // Last WAIT cycle before the operation is abandoned (unsigned compare).
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    state_e           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic             owner_q, owner_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             err_q, err_d;

    logic [1:0]       gnt;
    logic             gnt_id;

    rr_arb2 u_rr_arb2 (
        .i_req  (i_req_valid),
        .i_last (rr_last_q),
        .o_gnt  (gnt)
    );

    assign gnt_id = gnt[1];

    // Next-state, datapath capture and handshake outputs for the request FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        err_d       = err_q;
        o_req_ready = 2'b00;
        o_rsp_valid = 2'b00;
        o_fpu_start = 1'b0;

        case (state_q)
            IDLE: begin
                // Reset also masks the grant so every output reads 0 while held in reset.
                o_req_ready = i_reset_n ? gnt : 2'b00;
                if (|(gnt & i_req_valid)) begin
                    owner_d   = gnt_id;
                    rr_last_d = gnt_id;
                    op_d      = i_req_op[gnt_id];
                    a_d       = i_req_a[gnt_id];
                    b_d       = i_req_b[gnt_id];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                o_fpu_start = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the timeout cycle still delivers the real result.
                if (i_fpu_done) begin
                    data_d  = i_fpu_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    data_d  = FP_QNAN;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                o_rsp_valid[owner_q] = 1'b1;
                if (i_rsp_ready[owner_q]) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; an in-flight operation is dropped on reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign o_fpu_op   = op_q;
    assign o_fpu_a    = a_q;
    assign o_fpu_b    = b_q;
    assign o_rsp_data = data_q;
    assign o_rsp_err  = err_q;
    assign o_busy     = (state_q != IDLE);

endmodule
